// File: rtl/serial_addsub_pkg.sv
// Shared encodings for the multi-cycle adder/subtractor: FSM states and op modes.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_SUB = 1'b0;
  localparam logic MODE_ADD = 1'b1;

endpackage

// File: rtl/Three_States.sv
// Tri-state driver for the shared ULA result bus.
module Three_States #(
  parameter int N = 9
) (
  input  logic [N-1:0] i_data,
  input  logic         i_en,
  output tri   [N-1:0] o_bus
);

  assign o_bus = i_en ? i_data : {N{1'bz}};

endmodule

// File: rtl/addsub_slice.sv
// Combinational CHUNK-bit ripple slice; the same cells serve add (carry) and subtract (borrow).
module addsub_slice
  import serial_addsub_pkg::*;
#(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             mode,
  input  logic             cin,
  output logic [CHUNK-1:0] r,
  output logic             cout
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < CHUNK; gi++) begin : g_cell
      assign r[gi] = a[gi] ^ b[gi] ^ w_c[gi];
      // Borrow-out uses the inverted minuend; carry-out is the plain majority.
      assign w_c[gi+1] = (mode == MODE_ADD)
        ? ((a[gi] & b[gi]) | (a[gi] & w_c[gi]) | (b[gi] & w_c[gi]))
        : ((~a[gi] & b[gi]) | (~a[gi] & w_c[gi]) | (b[gi] & w_c[gi]));
    end
  endgenerate

  assign cout = w_c[CHUNK];

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, LSB first, with a registered carry/borrow.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             en,
  output logic             busy,
  output logic             done,
  output wire  [WIDTH:0]   s
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_mode;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cb;
  logic [WIDTH:0]   r_result;
  logic             r_busy;
  logic             r_done;

  logic [CHUNK-1:0] w_r;
  logic             w_cout;

  addsub_slice #(
    .CHUNK(CHUNK)
  ) u_slice (
    .a   (r_a[r_cnt*CHUNK +: CHUNK]),
    .b   (r_b[r_cnt*CHUNK +: CHUNK]),
    .mode(r_mode),
    .cin (r_cb),
    .r   (w_r),
    .cout(w_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_mode   <= MODE_SUB;
      r_cnt    <= '0;
      r_cb     <= 1'b0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          // The result is left alone here so it stays readable until the first RUN edge.
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_mode  <= mode;
            r_cnt   <= '0;
            r_cb    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_result[r_cnt*CHUNK +: CHUNK] <= w_r;
          r_cb  <= w_cout;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            r_result[WIDTH] <= w_cout;
            r_busy          <= 1'b0;
            r_done          <= 1'b1;
            r_state         <= ST_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;

  Three_States #(
    .N(WIDTH + 1)
  ) u_bus (
    .i_data(r_result),
    .i_en  (en),
    .o_bus (s)
  );

endmodule

// File: tb/tb_serial_addsub.sv
// Directed, table-driven bench for serial_addsub at 8/2 and 16/4 geometries.
module tb_serial_addsub;
  import serial_addsub_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start8 = 1'b0, mode8 = 1'b0, en8 = 1'b1;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8;
  wire  [8:0] s8;

  logic        start16 = 1'b0, mode16 = 1'b0, en16 = 1'b1;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16;
  wire  [16:0] s16;

  serial_addsub #(.WIDTH(8), .CHUNK(2)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode8), .a(a8), .b(b8),
    .en(en8), .busy(busy8), .done(done8), .s(s8)
  );

  serial_addsub #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .mode(mode16), .a(a16), .b(b16),
    .en(en16), .busy(busy16), .done(done16), .s(s16)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Entered at the negedge right after the accepting edge; returns edges until done.
  task automatic wait_done8(output int cyc, output int nbusy);
    cyc = 0;
    nbusy = 0;
    while (!done8 && cyc < 20) begin
      if (busy8) nbusy++;
      @(negedge clk);
      cyc++;
    end
    if (!done8) begin
      checks++;
      errors++;
      $display("FAIL timeout8: done never seen after %0d cycles", cyc);
    end
  endtask

  task automatic start_op8(input logic [7:0] a, input logic [7:0] b, input logic m);
    @(negedge clk);
    a8 = a; b8 = b; mode8 = m; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       mode;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int cyc, nbusy;

    vecs[0] = '{8'd200, 8'd55,  MODE_SUB, 9'h091};
    vecs[1] = '{8'd3,   8'd5,   MODE_SUB, 9'h1FE};
    vecs[2] = '{8'd0,   8'd0,   MODE_SUB, 9'h000};
    vecs[3] = '{8'd200, 8'd100, MODE_ADD, 9'h12C};
    vecs[4] = '{8'd255, 8'd1,   MODE_ADD, 9'h100};
    vecs[5] = '{8'd0,   8'd255, MODE_SUB, 9'h101};
    vecs[6] = '{8'd170, 8'd85,  MODE_ADD, 9'h0FF};

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_s8", {8'h00, s8}, 17'h0);
    chk("reset_busy8", {16'h0, busy8}, 17'h0);
    chk("reset_done8", {16'h0, done8}, 17'h0);
    chk("reset_s16", s16, 17'h0);

    // Table-driven vectors
    for (int i = 0; i < 7; i++) begin
      start_op8(vecs[i].a, vecs[i].b, vecs[i].mode);
      wait_done8(cyc, nbusy);
      $display("vec %0d: a=%0d b=%0d mode=%0d s=%h cyc=%0d", i, vecs[i].a, vecs[i].b,
               vecs[i].mode, s8, cyc);
      chk($sformatf("vec%0d_s", i), {8'h00, s8}, {8'h00, vecs[i].exp});
      chk($sformatf("vec%0d_latency", i), 17'(cyc), 17'd4);
      chk($sformatf("vec%0d_busycycles", i), 17'(nbusy), 17'd4);
      chk($sformatf("vec%0d_busy_at_done", i), {16'h0, busy8}, 17'h0);
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), {16'h0, done8}, 17'h0);
    end

    // start during RUN is ignored
    start_op8(8'd10, 8'd4, MODE_SUB);
    @(negedge clk);
    a8 = 8'd99; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    chk("ignored_busy", {16'h0, busy8}, 17'h1);
    @(negedge clk);
    @(negedge clk);
    chk("ignored_done", {16'h0, done8}, 17'h1);
    chk("ignored_s", {8'h00, s8}, 17'h006);

    // Back-to-back accept from DONE
    start_op8(8'd200, 8'd55, MODE_SUB);
    wait_done8(cyc, nbusy);
    chk("b2b_first_s", {8'h00, s8}, 17'h091);
    a8 = 8'd3; b8 = 8'd5; mode8 = MODE_SUB; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    chk("b2b_busy_no_idle", {16'h0, busy8}, 17'h1);
    chk("b2b_s_held", {8'h00, s8}, 17'h091);
    wait_done8(cyc, nbusy);
    chk("b2b_second_s", {8'h00, s8}, 17'h1FE);
    chk("b2b_latency", 17'(cyc), 17'd4);
    @(negedge clk);

    // Asynchronous reset mid-RUN
    start_op8(8'd200, 8'd55, MODE_SUB);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {16'h0, busy8}, 17'h0);
    chk("arst_s", {8'h00, s8}, 17'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done8) begin
        checks++;
        errors++;
        $display("FAIL arst_no_done: got done=1 expected 0 (cycle %0d)", k);
      end
    end
    start_op8(8'd3, 8'd5, MODE_ADD);
    wait_done8(cyc, nbusy);
    chk("arst_next_s", {8'h00, s8}, 17'h008);
    chk("arst_next_latency", 17'(cyc), 17'd4);
    @(negedge clk);

    // Output disabled through the operation
    en8 = 1'b0;
    start_op8(8'd200, 8'd55, MODE_SUB);
    wait_done8(cyc, nbusy);
    chk("en0_done_latency", 17'(cyc), 17'd4);
    checks++;
    if (s8 === 9'h091) begin
      errors++;
      $display("FAIL en0_bus_released: got %h expected not %h", s8, 9'h091);
    end
    en8 = 1'b1;
    #1;
    chk("en1_s", {8'h00, s8}, 17'h091);
    @(negedge clk);

    // 16-bit, 4-bit chunks
    begin
      logic [15:0] ta[3];
      logic [15:0] tb[3];
      logic        tm[3];
      logic [16:0] te[3];
      ta[0] = 16'h0000; tb[0] = 16'h0001; tm[0] = MODE_SUB; te[0] = 17'h1FFFF;
      ta[1] = 16'hFFFF; tb[1] = 16'hFFFF; tm[1] = MODE_ADD; te[1] = 17'h1FFFE;
      ta[2] = 16'h1234; tb[2] = 16'h0234; tm[2] = MODE_SUB; te[2] = 17'h01000;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        a16 = ta[i]; b16 = tb[i]; mode16 = tm[i]; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        cyc = 0;
        while (!done16 && cyc < 20) begin
          @(negedge clk);
          cyc++;
        end
        $display("w16 %0d: a=%h b=%h mode=%0d s=%h cyc=%0d", i, ta[i], tb[i], tm[i], s16, cyc);
        chk($sformatf("w16_%0d_s", i), s16, te[i]);
        chk($sformatf("w16_%0d_latency", i), 17'(cyc), 17'd4);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
